// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 datapath. It shares one memory port
// between fetch and load/store, counts retired instructions, and halts on end, illegal op or timeout.
// Ports: clk/rst (sync, active-high), run level, opcode/zero from the datapath, and a mem_req/mem_ready
//   handshake. Outputs: per-step strobes, state code, halt/error flags and the saturating retired count.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_END = 7'b0000000;

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  // Last wait count that may still be followed by another unanswered cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e             state_q, state_d;
  logic [6:0]         op_q, op_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               err_illegal_q, err_illegal_d;
  logic               err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic is_i, is_ld, is_st, is_br, op_ok;
  state_e boundary;

  assign is_i  = (op_q == OP_I);
  assign is_ld = (op_q == OP_LD);
  assign is_st = (op_q == OP_ST);
  assign is_br = (op_q == OP_BR);
  assign op_ok = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD) ||
                 (opcode == OP_ST) || (opcode == OP_BR);

  // Where an instruction goes once it retires: run is only consulted here.
  assign boundary = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    wait_cnt_d    = wait_cnt_q;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    retired_d     = retired_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_we        = 1'b0;
    halted        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (opcode == OP_END) begin
          state_d = S_HALT;
        end else if (op_ok) begin
          state_d = S_EXEC;
        end else begin
          state_d       = S_HALT;
          err_illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src = is_i || is_ld || is_st;
        if (is_br) begin
          pc_we   = 1'b1;
          pc_sel  = zero;
          state_d = boundary;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_st;
        alu_src = 1'b1;
        if (mem_ready) begin
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = boundary;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = is_ld;
        alu_src    = is_i || is_ld;
        pc_we      = 1'b1;
        state_d    = boundary;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An unanswered cycle at the last allowed count aborts the access; a
    // mem_ready in that same cycle never reaches this branch, so completion wins.
    if (mem_req && !mem_ready) begin
      if (wait_cnt_q == WAIT_LAST) begin
        state_d       = S_HALT;
        err_timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end

    // Every state entry starts a fresh wait window.
    if (state_d != state_q) wait_cnt_d = '0;

    if (pc_we && (retired_q != {CNT_W{1'b1}})) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      wait_cnt_q    <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      wait_cnt_q    <= wait_cnt_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
      retired_q     <= retired_d;
    end
  end

  assign state       = state_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: two instances share all inputs, one with a short memory
// timeout (MAX_WAIT=4) and one with a 2-bit retired counter to exercise saturation.
// Inputs change 1 time unit after the rising edge; outputs are checked in the same window.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst, run, zero, mem_ready;
  logic [6:0] opcode;

  logic        a_mem_req, a_mem_we, a_ir_we, a_pc_we, a_pc_sel, a_alu_src, a_mem_to_reg, a_reg_we;
  logic [2:0]  a_state;
  logic        a_halted, a_err_illegal, a_err_timeout;
  logic [31:0] a_retired;

  logic        b_mem_req, b_mem_we, b_ir_we, b_pc_we, b_pc_sel, b_alu_src, b_mem_to_reg, b_reg_we;
  logic [2:0]  b_state;
  logic        b_halted, b_err_illegal, b_err_timeout;
  logic [1:0]  b_retired;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .ir_we(a_ir_we), .pc_we(a_pc_we), .pc_sel(a_pc_sel),
    .alu_src(a_alu_src), .mem_to_reg(a_mem_to_reg), .reg_we(a_reg_we), .state(a_state),
    .halted(a_halted), .err_illegal(a_err_illegal), .err_timeout(a_err_timeout), .retired(a_retired)
  );

  multicycle_ctrl #(.MAX_WAIT(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .ir_we(b_ir_we), .pc_we(b_pc_we), .pc_sel(b_pc_sel),
    .alu_src(b_alu_src), .mem_to_reg(b_mem_to_reg), .reg_we(b_reg_we), .state(b_state),
    .halted(b_halted), .err_illegal(b_err_illegal), .err_timeout(b_err_timeout), .retired(b_retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = 7'b0;
    tick(); tick();
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_retired", a_retired, 32'd0);
    chk("rst_strobes", {a_mem_req, a_ir_we, a_pc_we, a_reg_we, a_halted, a_err_illegal, a_err_timeout}, 32'd0);

    // R-type, zero-wait memory: FETCH, DECODE, EXEC, WB.
    rst = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    tick();
    chk("r_fetch_state", 32'(a_state), 32'd1);
    chk("r_fetch_req_irwe", {a_mem_req, a_mem_we, a_ir_we}, 32'b101);
    tick();
    chk("r_decode_state", 32'(a_state), 32'd2);
    tick();
    chk("r_exec_state", 32'(a_state), 32'd3);
    chk("r_exec_strobes", {a_alu_src, a_pc_we, a_reg_we}, 32'b000);
    tick();
    chk("r_wb_state", 32'(a_state), 32'd5);
    chk("r_wb_strobes", {a_reg_we, a_pc_we, a_pc_sel, a_mem_to_reg, a_alu_src}, 32'b11000);
    chk("r_wb_retired_before", a_retired, 32'd0);
    run = 1'b0;
    tick();
    chk("r_idle_state", 32'(a_state), 32'd0);
    chk("r_retired", a_retired, 32'd1);

    // LOAD with three unanswered MEM cycles; the fourth answers at wait_cnt = MAX_WAIT-1.
    run = 1'b1; opcode = OP_LD;
    tick(); tick(); tick();
    chk("ld_exec_alusrc", {32'(a_state), a_alu_src}, {32'd3, 1'b1});
    mem_ready = 1'b0;
    tick();
    chk("ld_mem1", {a_state, a_mem_req, a_mem_we, a_alu_src}, {3'd4, 3'b101});
    tick(); tick(); tick();
    mem_ready = 1'b1;
    #1;
    chk("ld_mem4_req_held", {a_state, a_mem_req, a_halted}, {3'd4, 2'b10});
    tick();
    chk("ld_wb_state", 32'(a_state), 32'd5);
    chk("ld_wb_strobes", {a_reg_we, a_mem_to_reg, a_alu_src, a_pc_we, a_pc_sel}, 32'b11110);
    run = 1'b0;
    tick();
    chk("ld_retired", {a_state, a_retired}, {3'd0, 32'd2});

    // BRANCH taken then not taken, back to back.
    run = 1'b1; opcode = OP_BR; zero = 1'b1;
    tick(); tick(); tick();
    chk("br1_exec", {a_state, a_pc_we, a_pc_sel, a_reg_we, a_mem_req}, {3'd3, 4'b1100});
    zero = 1'b0;
    tick();
    chk("br1_next_fetch", {a_state, a_retired}, {3'd1, 32'd3});
    tick(); tick();
    chk("br0_exec", {a_state, a_pc_we, a_pc_sel, a_reg_we}, {3'd3, 3'b100});
    run = 1'b0;
    tick();
    chk("br0_retired", {a_state, a_retired}, {3'd0, 32'd4});

    // STORE: run drops during a MEM wait, store still completes and goes IDLE.
    run = 1'b1; opcode = OP_ST;
    tick(); tick(); tick();
    chk("st_exec_alusrc", {a_state, a_alu_src}, {3'd3, 1'b1});
    mem_ready = 1'b0;
    tick();
    chk("st_mem1", {a_state, a_mem_req, a_mem_we, a_pc_we}, {3'd4, 3'b110});
    run = 1'b0;
    tick();
    mem_ready = 1'b1;
    #1;
    chk("st_mem2_done", {a_state, a_mem_we, a_pc_we, a_pc_sel}, {3'd4, 3'b110});
    tick();
    chk("st_idle", {a_state, a_retired}, {3'd0, 32'd5});
    chk("sat_retired_b", 32'(b_retired), 32'd3);

    // Illegal opcode halts with err_illegal; run toggling does not leave HALT.
    run = 1'b1; opcode = 7'b1111111;
    tick(); tick(); tick();
    chk("ill_halt", {a_state, a_halted, a_err_illegal, a_err_timeout, a_mem_req, a_pc_we}, {3'd6, 5'b11000});
    run = 1'b0;
    tick();
    chk("ill_sticky", {a_state, a_err_illegal}, {3'd6, 1'b1});
    rst = 1'b1;
    tick();
    chk("ill_rst", {a_state, a_err_illegal, a_retired}, {3'd0, 1'b0, 32'd0});

    // All-zero opcode is a clean end: HALT without error.
    rst = 1'b0; run = 1'b1; opcode = 7'b0;
    tick(); tick(); tick();
    chk("end_halt", {a_state, a_halted, a_err_illegal, a_err_timeout}, {3'd6, 3'b100});
    rst = 1'b1;
    tick();

    // Fetch never answered: four unanswered cycles then HALT with err_timeout.
    rst = 1'b0; run = 1'b1; mem_ready = 1'b0; opcode = OP_R;
    tick();
    chk("to_fetch1", {a_state, a_mem_req}, {3'd1, 1'b1});
    tick(); tick(); tick();
    chk("to_fetch4", {a_state, a_halted}, {3'd1, 1'b0});
    tick();
    chk("to_halt", {a_state, a_halted, a_err_timeout, a_err_illegal, a_mem_req}, {3'd6, 4'b1100});
    chk("to_retired", a_retired, 32'd0);
    chk("to_b_still_fetch", {b_state, b_err_timeout}, {3'd1, 1'b0});
    run = 1'b0; tick(); run = 1'b1; tick();
    chk("to_run_ignored", {a_state, a_err_timeout}, {3'd6, 1'b1});
    rst = 1'b1;
    tick();
    chk("to_rst", {a_state, a_err_timeout}, {3'd0, 1'b0});

    // One R retires, then rst lands in EXEC of the next: aborted, counter cleared.
    rst = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    tick(); tick(); tick(); tick();
    tick(); tick(); tick();
    chk("rstx_exec", {a_state, a_retired}, {3'd3, 32'd1});
    rst = 1'b1;
    tick();
    chk("rstx_after", {a_state, a_retired, a_pc_we, a_reg_we}, {3'd0, 32'd0, 2'b00});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
